// File: rtl/adder_pkg.sv
// adder_pkg: shared defaults, segment-width helper and stage payload layout for pipelined_adder
package adder_pkg;
  localparam int DEF_WIDTH = 32;
  localparam int DEF_STAGES = 4;
  function automatic int seg_w(int width, int stages);
    return width / stages;
  endfunction
  typedef struct packed {
    logic [DEF_WIDTH-1:0] a;
    logic [DEF_WIDTH-1:0] b_eff;
    logic [DEF_WIDTH-1:0] psum;
    logic                 carry;
    logic                 a_msb;
    logic                 b_msb;
  } stage_payload_t;
endpackage

// File: rtl/add_stage.sv
// add_stage: one SEG-bit ripple segment at bit offset K*SEG with its payload/valid register; ports: v_i/ld_i in, a/b/s/c in and out, v_o out
module add_stage
  import adder_pkg::*;
#(
  parameter int W   = DEF_WIDTH,
  parameter int SEG = seg_w(DEF_WIDTH, DEF_STAGES),
  parameter int K   = 0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         v_i,
  input  logic         ld_i,
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic [W-1:0] s_i,
  input  logic         c_i,
  output logic         v_o,
  output logic [W-1:0] a_o,
  output logic [W-1:0] b_o,
  output logic [W-1:0] s_o,
  output logic         c_o
);
  typedef struct packed {
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic [W-1:0] s;
    logic         c;
  } payload_t;
  payload_t p_d, p_q;
  logic v_q;
  logic [SEG:0] seg;
  always_comb begin
    seg = {1'b0, a_i[K*SEG +: SEG]} + {1'b0, b_i[K*SEG +: SEG]} + {{SEG{1'b0}}, c_i};
    p_d = '{a: a_i, b: b_i, s: s_i, c: seg[SEG]};
    p_d.s[K*SEG +: SEG] = seg[SEG-1:0];
  end
  // payload only captured with a real op so a held result never changes under a bubble
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      v_q <= 1'b0;
      p_q <= '0;
    end else if (ld_i) begin
      v_q <= v_i;
      if (v_i) p_q <= p_d;
    end
  end
  assign v_o = v_q;
  assign a_o = p_q.a;
  assign b_o = p_q.b;
  assign s_o = p_q.s;
  assign c_o = p_q.c;
endmodule

// File: rtl/pipelined_adder.sv
// pipelined_adder: STAGES-deep add/subtract with valid/ready at both ends; ports clk, rst_n, in_valid/in_ready, a, b, cin, sub, out_valid/out_ready, sum, carry, overflow; define PIPELINED_ADDER_SAT_EN to clamp sum on signed overflow
module pipelined_adder
  import adder_pkg::*;
#(
  parameter int WIDTH  = DEF_WIDTH,
  parameter int STAGES = DEF_STAGES
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             carry,
  output logic             overflow
);
  localparam int SEG = seg_w(WIDTH, STAGES);
  logic [STAGES:0] v_w, c_w;
  logic [STAGES-1:0] ld_w;
  logic [STAGES:0][WIDTH-1:0] a_w, b_w, s_w;
  logic a_msb, b_msb, unused_bits;
  logic [WIDTH-1:0] raw;
  assign v_w[0] = in_valid;
  assign a_w[0] = a;
  assign b_w[0] = sub ? ~b : b;
  assign c_w[0] = sub | cin;
  assign s_w[0] = '0;
  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    // stage k may load if any register from k to the end is empty (a bubble downstream) or the sink takes the head
    assign ld_w[k] = out_ready | ~&v_w[STAGES:k+1];
    add_stage #(.W(WIDTH), .SEG(SEG), .K(k)) u_stage (
      .clk(clk), .rst_n(rst_n), .v_i(v_w[k]), .ld_i(ld_w[k]),
      .a_i(a_w[k]), .b_i(b_w[k]), .s_i(s_w[k]), .c_i(c_w[k]),
      .v_o(v_w[k+1]), .a_o(a_w[k+1]), .b_o(b_w[k+1]), .s_o(s_w[k+1]), .c_o(c_w[k+1])
    );
  end
  assign in_ready = ld_w[0];
  assign out_valid = v_w[STAGES];
  assign carry = c_w[STAGES];
  assign a_msb = a_w[STAGES][WIDTH-1];
  assign b_msb = b_w[STAGES][WIDTH-1];
  assign raw = s_w[STAGES];
  assign overflow = (a_msb == b_msb) & (raw[WIDTH-1] != a_msb);
  assign unused_bits = ^{a_w[STAGES][WIDTH-2:0], b_w[STAGES][WIDTH-2:0]};
`ifdef PIPELINED_ADDER_SAT_EN
  assign sum = overflow ? {a_msb, {(WIDTH-1){~a_msb}}} : raw;
`else
  assign sum = raw;
`endif
endmodule

// File: tb/tb_pipelined_adder.sv
// tb_pipelined_adder: directed and randomized checks of pipelined_adder against a signed/unsigned arithmetic model
module tb_pipelined_adder;
  localparam int W = 32;
  logic clk = 0, rst_n = 0, in_valid = 0, cin = 0, sub = 0, out_ready = 0;
  logic in_ready, out_valid, carry, overflow;
  logic [W-1:0] a = '0, b = '0, sum;
  typedef struct {logic [W-1:0] s; logic c; logic o;} exp_t;
  exp_t q[$];
  int vectors = 0, miscompares = 0, accepts = 0, outs = 0;
  logic ov;
  always #5 clk = ~clk;
  pipelined_adder dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .a(a), .b(b),
    .cin(cin), .sub(sub), .out_valid(out_valid), .out_ready(out_ready), .sum(sum),
    .carry(carry), .overflow(overflow)
  );
  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y, input logic ci, input logic s);
    exp_t e;
    longint sx, sy, r, mx, mn;
    logic [W:0] u;
    sx = longint'($signed(x));
    sy = longint'($signed(y));
    mx = (longint'(1) <<< (W - 1)) - 1;
    mn = -(longint'(1) <<< (W - 1));
    u = s ? ({1'b0, x} - {1'b0, y}) : ({1'b0, x} + {1'b0, y} + {{W{1'b0}}, ci});
    r = s ? sx - sy : sx + sy + longint'(ci);
    e.c = s ? (x >= y) : u[W];
    e.o = (r > mx) || (r < mn);
    e.s = u[W-1:0];
`ifdef PIPELINED_ADDER_SAT_EN
    if (e.o) e.s = (sx < 0) ? W'(mn) : W'(mx);
`endif
    return e;
  endfunction
  task automatic cycle(input logic iv, input logic [W-1:0] x, input logic [W-1:0] y,
                       input logic ci, input logic s, input logic ordy);
    exp_t e;
    @(negedge clk);
    in_valid = iv; a = x; b = y; cin = ci; sub = s; out_ready = ordy;
    #1;
    ov = out_valid;
    if (in_valid && in_ready) begin
      q.push_back(model(x, y, ci, s));
      accepts++;
    end
    if (out_valid && out_ready) begin
      outs++;
      if (q.size() == 0) chk("spurious_out", {63'b0, out_valid}, 64'd0);
      else begin
        e = q.pop_front();
        chk("sum", 64'(sum), 64'(e.s));
        chk("carry", 64'(carry), 64'(e.c));
        chk("ovf", 64'(overflow), 64'(e.o));
      end
    end
  endtask
  task automatic idle(input logic ordy);
    cycle(1'b0, $urandom, $urandom, 1'($urandom), 1'($urandom), ordy);
  endtask
  task automatic drain();
    for (int i = 0; i < 60 && q.size() != 0; i++) idle(1'b1);
    chk("drain_empty", 64'(q.size()), 64'd0);
  endtask
  initial begin
    logic [W-1:0] hs;
    logic hv;
    int n0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_sum", 64'(sum), 64'd0);
    chk("rst_carry", 64'(carry), 64'd0);
    chk("rst_ovf", 64'(overflow), 64'd0);
    repeat (2) @(negedge clk);
    rst_n = 1;
    idle(1'b1);
    chk("rel_in_ready", 64'(in_ready), 64'd1);
    cycle(1'b1, 32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
    repeat (3) begin
      idle(1'b1);
      chk("lat_early", 64'(ov), 64'd0);
    end
    idle(1'b1);
    chk("lat_valid", 64'(ov), 64'd1);
    chk("t1_sum", 64'(sum), 64'd0);
    chk("t1_carry", 64'(carry), 64'd1);
    chk("t1_ovf", 64'(overflow), 64'd0);
    cycle(1'b1, 32'd5, 32'd7, 1'b1, 1'b1, 1'b1);
    cycle(1'b1, 32'd7, 32'd5, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'h7FFF_FFFF, 32'd1, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1);
    cycle(1'b1, 32'h8000_0000, 32'd1, 1'b0, 1'b1, 1'b1);
    cycle(1'b1, 32'd0, 32'h8000_0000, 1'b1, 1'b1, 1'b1);
    drain();
    n0 = accepts;
    hv = 1'b0;
    hs = '0;
    repeat (10) begin
      cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b0);
      if (ov) begin
        if (!hv) begin
          hs = sum;
          hv = 1'b1;
        end else chk("stall_hold", 64'(sum), 64'(hs));
      end
    end
    chk("stall_accepts", 64'(accepts - n0), 64'd4);
    chk("full_in_ready", 64'(in_ready), 64'd0);
    n0 = outs;
    cycle(1'b1, $urandom, $urandom, 1'($urandom), 1'($urandom), 1'b1);
    chk("release_in_ready", 64'(in_ready), 64'd1);
    repeat (3) idle(1'b1);
    chk("release_burst", 64'(outs - n0), 64'd4);
    drain();
    repeat (3) cycle(1'b1, 32'h1234, 32'd1, 1'b0, 1'b0, 1'b0);
    repeat (2) idle(1'b0);
    chk("pre_rst_valid", 64'(ov), 64'd1);
    rst_n = 0;
    #1;
    chk("async_out_valid", 64'(out_valid), 64'd0);
    chk("async_sum", 64'(sum), 64'd0);
    chk("async_carry", 64'(carry), 64'd0);
    q.delete();
    @(negedge clk);
    rst_n = 1;
    n0 = outs;
    repeat (10) idle(1'b1);
    chk("no_stale", 64'(outs - n0), 64'd0);
    n0 = accepts;
    for (int i = 0; i < 6000 && accepts < n0 + 1000; i++)
      cycle(($urandom % 4) != 0, $urandom, $urandom, 1'($urandom), 1'($urandom), ($urandom % 4) != 0);
    chk("rand_accepts", 64'(accepts - n0), 64'd1000);
    drain();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
